// File: rtl/param_decoder_seq.sv
// -----------------------------------------------------------------------------
// param_decoder_seq
//   Registered IN_W-to-NUM_OUT one-hot decoder with a valid/ready input
//   handshake. It drives one-hot select and strobe lines for register banks
//   and datapath muxes.
//
//   MODE = 0 (level): a code can be accepted on every cycle. q keeps its last
//                     value until the next accept.
//   MODE = 1 (pulse): q is high for PULSE_LEN cycles after an accept. q is then
//                     low for at least one cycle before another code can be
//                     accepted.
//
//   An out-of-range code (d >= NUM_OUT) loads q = 0. q_valid still pulses for
//   that code. In pulse mode the code still takes the full pulse slot, so the
//   throughput does not depend on the data.
//
//   Optional build macro DEC_ERR_EN
//     If defined, err is a sticky out-of-range flag and err_clr clears it.
//     If both happen on the same edge, the set wins.
//     If undefined, err is tied to 0 and err_clr is ignored.
//
// Parameters
//   IN_W       width of d
//   NUM_OUT    number of one-hot outputs (2 .. 2**IN_W)
//   MODE       0 = level, 1 = pulse
//   PULSE_LEN  pulse length in cycles (1 .. 255); used only when MODE = 1
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   synchronous reset, active low
//   d_valid  in   the code on d is valid
//   d_ready  out  the block can accept a code this cycle (0 during reset)
//   d        in   code to decode
//   q        out  registered one-hot output
//   q_valid  out  one-cycle strobe: q was loaded on the previous edge
//   err      out  sticky out-of-range flag (tied 0 without DEC_ERR_EN)
//   err_clr  in   clears err (ignored without DEC_ERR_EN)
//
// Pulse-mode FSM
//   state | meaning
//   IDLE  | q = 0, d_ready = 1, waiting for an accept
//   PULSE | q is being driven, d_ready = 0, cnt = cycles left after this one
// -----------------------------------------------------------------------------
module param_decoder_seq #(
  parameter int IN_W      = 3,
  parameter int NUM_OUT   = 8,
  parameter int MODE      = 0,
  parameter int PULSE_LEN = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               d_valid,
  output logic               d_ready,
  input  logic [IN_W-1:0]    d,
  output logic [NUM_OUT-1:0] q,
  output logic               q_valid,
  output logic               err,
  input  logic               err_clr
);

  localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN - 1);

  if (NUM_OUT < 2 || NUM_OUT > (2 ** IN_W)) begin : g_bad_num_out
    $error("param_decoder_seq: NUM_OUT out of range 2..2**IN_W");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("param_decoder_seq: MODE must be 0 or 1");
  end
  if (MODE == 1 && (PULSE_LEN < 1 || PULSE_LEN > 255)) begin : g_bad_pulse_len
    $error("param_decoder_seq: PULSE_LEN out of range 1..255");
  end

  logic               accept;
  logic [NUM_OUT-1:0] dec;

  // Each output bit is an equality match, so the decode cannot be multi-hot.
  // An out-of-range code matches no bit and decodes to all zeros.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      dec[i] = (d == IN_W'(i));
    end
  end

  assign accept = d_valid & d_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
    end else begin
      q_valid <= accept;
    end
  end

  if (MODE == 0) begin : g_level

    assign d_ready = reset_n;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        q <= '0;
      end else if (accept) begin
        q <= dec;
      end
    end

  end else begin : g_pulse

    typedef enum logic {
      IDLE  = 1'b0,
      PULSE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cnt;
    logic [7:0]         cnt_nxt;
    logic [NUM_OUT-1:0] q_nxt;

    // State register
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state <= IDLE;
        cnt   <= 8'd0;
        q     <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        q     <= q_nxt;
      end
    end

    // Next-state logic
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (accept) state_nxt = PULSE;
        PULSE:   if (cnt == 8'd0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Output and datapath logic.
    // The counter is loaded with PULSE_LEN-1 because the accept edge already
    // starts the first high cycle of q.
    always_comb begin
      d_ready = reset_n && (state == IDLE);
      q_nxt   = q;
      cnt_nxt = cnt;
      case (state)
        IDLE: begin
          if (accept) begin
            q_nxt   = dec;
            cnt_nxt = PULSE_INIT;
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            q_nxt = '0;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        default: begin
          q_nxt   = '0;
          cnt_nxt = 8'd0;
        end
      endcase
    end

  end

`ifdef DEC_ERR_EN
  logic in_range;

  assign in_range = |dec;

  // A new out-of-range accept wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (accept && !in_range) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign err            = 1'b0;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_param_decoder_seq.sv
module tb_param_decoder_seq;

`ifdef DEC_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // u0: level mode, 3 -> 8
  logic       dv0, rdy0, qv0, err0, clr0;
  logic [2:0] d0;
  logic [7:0] q0;

  // u1: pulse mode, PULSE_LEN = 3
  logic       dv1, rdy1, qv1, err1, clr1;
  logic [2:0] d1;
  logic [7:0] q1;

  // u2: level mode, NUM_OUT = 6 (out-of-range codes and err)
  logic       dv2, rdy2, qv2, err2, clr2;
  logic [2:0] d2;
  logic [5:0] q2;

  // u3: pulse mode, PULSE_LEN = 4 (reset in the middle of a pulse)
  logic       dv3, rdy3, qv3, err3, clr3;
  logic [2:0] d3;
  logic [7:0] q3;

  // u4: level mode, 4 -> 16
  logic        dv4, rdy4, qv4, err4, clr4;
  logic [3:0]  d4;
  logic [15:0] q4;

  // u5: level mode, 5 -> 20
  logic        dv5, rdy5, qv5, err5, clr5;
  logic [4:0]  d5;
  logic [19:0] q5;

  param_decoder_seq #(.IN_W(3), .NUM_OUT(8), .MODE(0), .PULSE_LEN(1)) u0 (
    .clk(clk), .reset_n(reset_n), .d_valid(dv0), .d_ready(rdy0), .d(d0),
    .q(q0), .q_valid(qv0), .err(err0), .err_clr(clr0));
  param_decoder_seq #(.IN_W(3), .NUM_OUT(8), .MODE(1), .PULSE_LEN(3)) u1 (
    .clk(clk), .reset_n(reset_n), .d_valid(dv1), .d_ready(rdy1), .d(d1),
    .q(q1), .q_valid(qv1), .err(err1), .err_clr(clr1));
  param_decoder_seq #(.IN_W(3), .NUM_OUT(6), .MODE(0), .PULSE_LEN(1)) u2 (
    .clk(clk), .reset_n(reset_n), .d_valid(dv2), .d_ready(rdy2), .d(d2),
    .q(q2), .q_valid(qv2), .err(err2), .err_clr(clr2));
  param_decoder_seq #(.IN_W(3), .NUM_OUT(8), .MODE(1), .PULSE_LEN(4)) u3 (
    .clk(clk), .reset_n(reset_n), .d_valid(dv3), .d_ready(rdy3), .d(d3),
    .q(q3), .q_valid(qv3), .err(err3), .err_clr(clr3));
  param_decoder_seq #(.IN_W(4), .NUM_OUT(16), .MODE(0), .PULSE_LEN(1)) u4 (
    .clk(clk), .reset_n(reset_n), .d_valid(dv4), .d_ready(rdy4), .d(d4),
    .q(q4), .q_valid(qv4), .err(err4), .err_clr(clr4));
  param_decoder_seq #(.IN_W(5), .NUM_OUT(20), .MODE(0), .PULSE_LEN(1)) u5 (
    .clk(clk), .reset_n(reset_n), .d_valid(dv5), .d_ready(rdy5), .d(d5),
    .q(q5), .q_valid(qv5), .err(err5), .err_clr(clr5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_q4, exp_q5;
  logic        exp_v4, exp_v5;
  int          n_sweep_fail;

  initial begin
    // Reset held for 3 cycles with a valid code pending on every instance
    reset_n = 1'b0;
    dv0 = 1'b1; d0 = 3'd5; clr0 = 1'b0;
    dv1 = 1'b1; d1 = 3'd5; clr1 = 1'b0;
    dv2 = 1'b1; d2 = 3'd5; clr2 = 1'b0;
    dv3 = 1'b1; d3 = 3'd5; clr3 = 1'b0;
    dv4 = 1'b1; d4 = 4'd5; clr4 = 1'b0;
    dv5 = 1'b1; d5 = 5'd5; clr5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_q",       32'(q0),   32'h0);
      chk("rst_q_valid", 32'(qv0),  32'h0);
      chk("rst_err",     32'(err2), 32'h0);
      chk("rst_ready0",  32'(rdy0), 32'h0);
      chk("rst_ready1",  32'(rdy1), 32'h0);
      chk("rst_q1",      32'(q1),   32'h0);
    end
    reset_n = 1'b1;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0; dv3 = 1'b0; dv4 = 1'b0; dv5 = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(rdy0), 32'h1);
    chk("post_rst_ready1", 32'(rdy1), 32'h1);

    // Level mode: back-to-back accepts of 0..7
    dv0 = 1'b1;
    d0  = 3'd0;
    #1;
    chk("lvl_no_comb_path", 32'(q0), 32'h0);
    for (int i = 0; i < 8; i++) begin
      d0 = 3'(i);
      tick();
      chk("lvl_q",       32'(q0),   32'h1 << i);
      chk("lvl_q_valid", 32'(qv0),  32'h1);
      chk("lvl_ready",   32'(rdy0), 32'h1);
    end
    dv0 = 1'b0;
    d0  = 3'd3;
    tick();
    chk("lvl_hold_q",       32'(q0),  32'h80);
    chk("lvl_hold_q_valid", 32'(qv0), 32'h0);
    tick();
    chk("lvl_hold_q2",      32'(q0),  32'h80);

    // Pulse mode, PULSE_LEN = 3: d=2, then d=6 held through the busy cycles
    dv1 = 1'b1;
    d1  = 3'd2;
    tick();
    d1 = 3'd6;
    chk("pls_c1_q",       32'(q1),   32'h04);
    chk("pls_c1_q_valid", 32'(qv1),  32'h1);
    chk("pls_c1_ready",   32'(rdy1), 32'h0);
    tick();
    chk("pls_c2_q",       32'(q1),   32'h04);
    chk("pls_c2_q_valid", 32'(qv1),  32'h0);
    chk("pls_c2_ready",   32'(rdy1), 32'h0);
    tick();
    chk("pls_c3_q",       32'(q1),   32'h04);
    chk("pls_c3_ready",   32'(rdy1), 32'h0);
    tick();
    chk("pls_idle_q",     32'(q1),   32'h00);
    chk("pls_idle_ready", 32'(rdy1), 32'h1);
    tick();
    dv1 = 1'b0;
    chk("pls_next_q",       32'(q1),   32'h40);
    chk("pls_next_q_valid", 32'(qv1),  32'h1);
    chk("pls_next_ready",   32'(rdy1), 32'h0);
    tick();
    tick();
    chk("pls_next_c3_q", 32'(q1), 32'h40);
    tick();
    chk("pls_next_end_q", 32'(q1),   32'h00);
    chk("pls_next_end_r", 32'(rdy1), 32'h1);

    // NUM_OUT = 6: out-of-range codes and err handling
    dv2 = 1'b1;
    d2  = 3'd5;
    tick();
    chk("oor_top_q", 32'(q2), 32'h20);
    d2 = 3'd6;
    tick();
    chk("oor6_q",       32'(q2),   32'h0);
    chk("oor6_q_valid", 32'(qv2),  32'h1);
    chk("oor6_err",     32'(err2), 32'(ERR_BUILD));
    d2   = 3'd7;
    clr2 = 1'b1;
    tick();
    chk("oor7_clr_q",   32'(q2),   32'h0);
    chk("oor7_clr_err", 32'(err2), 32'(ERR_BUILD));
    dv2 = 1'b0;
    tick();
    clr2 = 1'b0;
    chk("clr_err",     32'(err2), 32'h0);
    chk("clr_q_valid", 32'(qv2),  32'h0);

    // Pulse mode, PULSE_LEN = 4: reset during the 2nd pulse cycle
    dv3 = 1'b1;
    d3  = 3'd1;
    tick();
    dv3 = 1'b0;
    chk("prst_c1_q", 32'(q3), 32'h02);
    tick();
    chk("prst_c2_q", 32'(q3), 32'h02);
    reset_n = 1'b0;
    #1;
    chk("prst_ready_low", 32'(rdy3), 32'h0);
    tick();
    chk("prst_q",       32'(q3),   32'h0);
    chk("prst_q_valid", 32'(qv3),  32'h0);
    chk("prst_ready",   32'(rdy3), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("prst_rel_ready", 32'(rdy3), 32'h1);
    tick();
    chk("prst_idle_q",     32'(q3),   32'h0);
    chk("prst_idle_ready", 32'(rdy3), 32'h1);
    dv3 = 1'b1;
    d3  = 3'd7;
    tick();
    dv3 = 1'b0;
    chk("prst_new_q", 32'(q3), 32'h80);

    // Random sweep on the 4->16 and 5->20 decoders
    n_sweep_fail = 0;
    for (int c = 0; c < 2000; c++) begin
      dv4 = 1'($urandom_range(0, 1));
      d4  = 4'($urandom_range(0, 15));
      dv5 = 1'($urandom_range(0, 1));
      d5  = 5'($urandom_range(0, 31));
      exp_v4 = dv4;
      exp_v5 = dv5;
      if (dv4) exp_q4 = 32'h1 << d4;
      if (dv5) exp_q5 = (d5 < 5'd20) ? (32'h1 << d5) : 32'h0;
      tick();
      if (c == 0) begin
        // Before the first accept, both decoders still hold 0 from reset
        if (!dv4) exp_q4 = 32'h0;
        if (!dv5) exp_q5 = 32'h0;
      end
      chk("swp16_q",      32'(q4),  exp_q4);
      chk("swp16_valid",  32'(qv4), 32'(exp_v4));
      chk("swp20_q",      32'(q5),  exp_q5);
      chk("swp20_valid",  32'(qv5), 32'(exp_v5));
      chk("swp16_onehot", 32'($countones(q4) <= 1), 32'h1);
      chk("swp20_onehot", 32'($countones(q5) <= 1), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the bench cannot hang
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
